// File: rtl/cpu_ctrl_pkg.sv
// Control-word types and LEGv8 opcode match constants shared by the control pipeline.
package cpu_ctrl_pkg;

    typedef struct packed {
        logic reg2loc;
        logic alu_src;
        logic alu_sh;
        logic imm;
        logic shift_dirn;
        logic alu_on;
        logic set_flags;
    } ctrl_ex_t;

    typedef struct packed {
        logic mem_write;
        logic branch;
        logic uncond_br;
        logic branch_reg;
        logic branch_link;
    } ctrl_mem_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } ctrl_wb_t;

    typedef struct packed {
        ctrl_ex_t  ex;
        ctrl_mem_t mem;
        ctrl_wb_t  wb;
    } ctrl_word_t;

    // Each constant matches the leading bits of the 11-bit opcode; its width is the match length.
    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
    localparam logic [5:0]  OP_BL    = 6'b100101;
    localparam logic [10:0] OP_BR    = 11'b11010110000;
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
    localparam logic [10:0] OP_ADDS  = 11'b10101011000;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [10:0] OP_SUBS  = 11'b11101011000;

    localparam ctrl_word_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational LEGv8 opcode decoder: first matching entry wins, no match flags illegal.
module ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned OPC_W = 11,
    parameter bit          EN_BL = 1'b1,
    parameter bit          EN_BR = 1'b1
) (
    input  logic [OPC_W-1:0] opcode_i,
    output ctrl_word_t       ctrl_o,
    output logic             illegal_o
);

    logic [10:0] op;
    assign op = opcode_i[OPC_W-1 -: 11];

    always_comb begin
        ctrl_o    = CTRL_NOP;
        illegal_o = 1'b0;
        if (op[10:5] == OP_B) begin
            ctrl_o.mem.branch    = 1'b1;
            ctrl_o.mem.uncond_br = 1'b1;
        end else if (op[10:3] == OP_BCOND) begin
            ctrl_o.mem.branch = 1'b1;
        end else if (EN_BL && (op[10:5] == OP_BL)) begin
            // BL writes the return address into the link register.
            ctrl_o.mem.branch      = 1'b1;
            ctrl_o.mem.uncond_br   = 1'b1;
            ctrl_o.mem.branch_link = 1'b1;
            ctrl_o.wb.reg_write    = 1'b1;
        end else if (EN_BR && (op == OP_BR)) begin
            ctrl_o.mem.branch     = 1'b1;
            ctrl_o.mem.uncond_br  = 1'b1;
            ctrl_o.mem.branch_reg = 1'b1;
        end else if (op[10:3] == OP_CBZ) begin
            ctrl_o.ex.alu_on  = 1'b1;
            ctrl_o.mem.branch = 1'b1;
        end else if (op[10:1] == OP_ADDI) begin
            ctrl_o.ex.alu_src   = 1'b1;
            ctrl_o.ex.imm       = 1'b1;
            ctrl_o.ex.alu_on    = 1'b1;
            ctrl_o.wb.reg_write = 1'b1;
        end else if ((op == OP_ADDS) || (op == OP_SUBS)) begin
            ctrl_o.ex.reg2loc   = 1'b1;
            ctrl_o.ex.alu_on    = 1'b1;
            ctrl_o.ex.set_flags = 1'b1;
            ctrl_o.wb.reg_write = 1'b1;
        end else if (op == OP_LDUR) begin
            ctrl_o.ex.alu_src    = 1'b1;
            ctrl_o.ex.alu_on     = 1'b1;
            ctrl_o.wb.reg_write  = 1'b1;
            ctrl_o.wb.mem_to_reg = 1'b1;
        end else if (op == OP_STUR) begin
            ctrl_o.ex.alu_src    = 1'b1;
            ctrl_o.ex.alu_on     = 1'b1;
            ctrl_o.mem.mem_write = 1'b1;
        end else begin
            illegal_o = 1'b1;
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Decodes accepted opcodes and carries the control word through EX, MEM and WB registers
// with hazard stall and branch flush.
module ctrl_pipe
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned OPC_W = 11,
    parameter bit          EN_BL = 1'b1,
    parameter bit          EN_BR = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPC_W-1:0] opcode,
    input  logic             stall,
    input  logic             flush,
    output ctrl_ex_t         ex_ctrl,
    output ctrl_mem_t        mem_ctrl,
    output ctrl_wb_t         wb_ctrl,
    output logic             ex_valid,
    output logic             mem_valid,
    output logic             wb_valid,
    output logic             illegal
);

    ctrl_word_t dec_word;
    logic       dec_illegal;

    ctrl_word_t ex_d, ex_q;
    logic       ex_valid_d, ex_valid_q;
    ctrl_mem_t  mem_d, mem_q;
    ctrl_wb_t   mem_wb_d, mem_wb_q;
    logic       mem_valid_d, mem_valid_q;
    ctrl_wb_t   wb_d, wb_q;
    logic       wb_valid_d, wb_valid_q;
    logic       illegal_d, illegal_q;

    ctrl_decode #(
        .OPC_W (OPC_W),
        .EN_BL (EN_BL),
        .EN_BR (EN_BR)
    ) u_decode (
        .opcode_i  (opcode),
        .ctrl_o    (dec_word),
        .illegal_o (dec_illegal)
    );

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_d       = ex_q;
        // Flush beats stall: a killed EX slot never holds.
        if (flush) begin
            ex_valid_d = 1'b0;
            ex_d       = CTRL_NOP;
        end else if (!stall) begin
            ex_valid_d = in_valid;
            ex_d       = in_valid ? dec_word : CTRL_NOP;
        end

        mem_valid_d = ex_valid_q && !stall;
        mem_d       = mem_valid_d ? ex_q.mem : '0;
        mem_wb_d    = mem_valid_d ? ex_q.wb : '0;

        wb_valid_d = mem_valid_q;
        wb_d       = mem_valid_q ? mem_wb_q : '0;

        illegal_d = in_valid && !stall && !flush && dec_illegal;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q        <= CTRL_NOP;
            ex_valid_q  <= 1'b0;
            mem_q       <= '0;
            mem_wb_q    <= '0;
            mem_valid_q <= 1'b0;
            wb_q        <= '0;
            wb_valid_q  <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            ex_q        <= ex_d;
            ex_valid_q  <= ex_valid_d;
            mem_q       <= mem_d;
            mem_wb_q    <= mem_wb_d;
            mem_valid_q <= mem_valid_d;
            wb_q        <= wb_d;
            wb_valid_q  <= wb_valid_d;
            illegal_q   <= illegal_d;
        end
    end

    always_comb begin
        in_ready  = !stall;
        ex_valid  = ex_valid_q;
        mem_valid = mem_valid_q;
        wb_valid  = wb_valid_q;
        ex_ctrl   = ex_valid_q ? ex_q.ex : '0;
        mem_ctrl  = mem_valid_q ? mem_q : '0;
        wb_ctrl   = wb_valid_q ? wb_q : '0;
        illegal   = illegal_q;
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Randomized bench for ctrl_pipe: an instruction-level pipeline model predicts every output.
module tb_ctrl_pipe;
    import cpu_ctrl_pkg::*;

    localparam logic [10:0] LDUR = 11'b11111000010;
    localparam logic [10:0] STUR = 11'b11111000000;
    localparam logic [10:0] ADDS = 11'b10101011000;
    localparam logic [10:0] SUBS = 11'b11101011000;
    localparam logic [10:0] CBZ  = 11'b10110100101;
    localparam logic [10:0] ADDI = 11'b10010001001;
    localparam logic [10:0] BL   = 11'b10010111001;
    localparam logic [10:0] BAD  = 11'b11111111111;

    localparam int K_NONE = -1, K_ILL = 0, K_B = 1, K_BCOND = 2, K_BL = 3, K_BR = 4;
    localparam int K_CBZ = 5, K_ADDI = 6, K_ADDS = 7, K_LDUR = 8, K_STUR = 9, K_SUBS = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [10:0] opcode = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;

    logic      rdy_a, exv_a, memv_a, wbv_a, ill_a;
    ctrl_ex_t  exc_a;
    ctrl_mem_t memc_a;
    ctrl_wb_t  wbc_a;
    logic      rdy_b, exv_b, memv_b, wbv_b, ill_b;
    ctrl_ex_t  exc_b;
    ctrl_mem_t memc_b;
    ctrl_wb_t  wbc_b;

    int n_checks = 0;
    int n_errors = 0;

    // Per-instance model: kind of instruction occupying each stage (K_NONE = bubble).
    int m_ex[2], m_mem[2], m_wb[2];
    bit m_ill[2];

    always #5 clk = ~clk;

    ctrl_pipe u_dut (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (rdy_a), .opcode (opcode),
        .stall (stall), .flush (flush), .ex_ctrl (exc_a), .mem_ctrl (memc_a),
        .wb_ctrl (wbc_a), .ex_valid (exv_a), .mem_valid (memv_a), .wb_valid (wbv_a),
        .illegal (ill_a)
    );

    ctrl_pipe #(.OPC_W (11), .EN_BL (1'b0), .EN_BR (1'b1)) u_dut_nobl (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (rdy_b), .opcode (opcode),
        .stall (stall), .flush (flush), .ex_ctrl (exc_b), .mem_ctrl (memc_b),
        .wb_ctrl (wbc_b), .ex_valid (exv_b), .mem_valid (memv_b), .wb_valid (wbv_b),
        .illegal (ill_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int classify(input logic [10:0] op, input bit en_bl);
        casez (op)
            11'b000101?????: return K_B;
            11'b01010100???: return K_BCOND;
            11'b100101?????: return en_bl ? K_BL : K_ILL;
            11'b11010110000: return K_BR;
            11'b10110100???: return K_CBZ;
            11'b1001000100?: return K_ADDI;
            11'b10101011000: return K_ADDS;
            11'b11111000010: return K_LDUR;
            11'b11111000000: return K_STUR;
            11'b11101011000: return K_SUBS;
            default:         return K_ILL;
        endcase
    endfunction

    function automatic ctrl_ex_t exp_ex(input int k);
        ctrl_ex_t e = '0;
        e.reg2loc   = (k == K_ADDS) || (k == K_SUBS);
        e.alu_src   = (k == K_ADDI) || (k == K_LDUR) || (k == K_STUR);
        e.imm       = (k == K_ADDI);
        e.alu_on    = (k inside {K_ADDI, K_ADDS, K_SUBS, K_LDUR, K_STUR, K_CBZ});
        e.set_flags = (k == K_ADDS) || (k == K_SUBS);
        return e;
    endfunction

    function automatic ctrl_mem_t exp_mem(input int k);
        ctrl_mem_t m = '0;
        m.mem_write   = (k == K_STUR);
        m.branch      = (k inside {K_B, K_BCOND, K_BL, K_BR, K_CBZ});
        m.uncond_br   = (k inside {K_B, K_BL, K_BR});
        m.branch_reg  = (k == K_BR);
        m.branch_link = (k == K_BL);
        return m;
    endfunction

    function automatic ctrl_wb_t exp_wb(input int k);
        ctrl_wb_t w = '0;
        w.reg_write  = (k inside {K_ADDI, K_ADDS, K_SUBS, K_LDUR, K_BL});
        w.mem_to_reg = (k == K_LDUR);
        return w;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ex[d] = K_NONE; m_mem[d] = K_NONE; m_wb[d] = K_NONE; m_ill[d] = 1'b0;
        end
    endtask

    task automatic model_advance(input int d, input int k, input logic v, input logic st,
                                 input logic fl);
        m_wb[d]  = m_mem[d];
        m_mem[d] = st ? K_NONE : m_ex[d];
        m_ill[d] = v && !st && !fl && (k == K_ILL);
        if (fl) m_ex[d] = K_NONE;
        else if (!st) m_ex[d] = v ? k : K_NONE;
    endtask

    task automatic check_dut(input string n, input int d, input logic exv, input logic memv,
                             input logic wbv, input ctrl_ex_t exc, input ctrl_mem_t memc,
                             input ctrl_wb_t wbc, input logic ill);
        check_eq({n, ".ex_valid"}, 32'(exv), 32'(m_ex[d] != K_NONE));
        check_eq({n, ".mem_valid"}, 32'(memv), 32'(m_mem[d] != K_NONE));
        check_eq({n, ".wb_valid"}, 32'(wbv), 32'(m_wb[d] != K_NONE));
        check_eq({n, ".ex_ctrl"}, 32'(exc), 32'(exp_ex(m_ex[d])));
        check_eq({n, ".mem_ctrl"}, 32'(memc), 32'(exp_mem(m_mem[d])));
        check_eq({n, ".wb_ctrl"}, 32'(wbc), 32'(exp_wb(m_wb[d])));
        check_eq({n, ".illegal"}, 32'(ill), 32'(m_ill[d]));
    endtask

    task automatic check_all();
        check_dut("a", 0, exv_a, memv_a, wbv_a, exc_a, memc_a, wbc_a, ill_a);
        check_dut("b", 1, exv_b, memv_b, wbv_b, exc_b, memc_b, wbc_b, ill_b);
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input logic v, input logic [10:0] op, input logic st, input logic fl);
        in_valid = v; opcode = op; stall = st; flush = fl;
        #1;
        check_eq("in_ready_a", 32'(rdy_a), 32'(!st));
        check_eq("in_ready_b", 32'(rdy_b), 32'(!st));
        @(posedge clk);
        model_advance(0, classify(op, 1'b1), v, st, fl);
        model_advance(1, classify(op, 1'b0), v, st, fl);
        @(negedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        step(1'b0, 11'($urandom), 1'b0, 1'b0);
    endtask

    function automatic logic [10:0] rand_op();
        logic [10:0] r;
        r = 11'($urandom);
        case ($urandom_range(0, 11))
            0:       return {6'b000101, r[4:0]};
            1:       return {8'b01010100, r[2:0]};
            2:       return {6'b100101, r[4:0]};
            3:       return 11'b11010110000;
            4:       return {8'b10110100, r[2:0]};
            5:       return {10'b1001000100, r[0]};
            6:       return ADDS;
            7:       return LDUR;
            8:       return STUR;
            9:       return SUBS;
            default: return r;
        endcase
    endfunction

    initial begin
        int cnt;
        model_reset();
        in_valid = 1'b1; opcode = LDUR;
        #1 rst = 1'b0;
        #1 check_all();
        @(negedge clk); #1 check_all();
        @(negedge clk); #1 check_all();
        rst = 1'b1;

        // LDUR latency and fields, first capture right after reset release.
        step(1'b1, LDUR, 1'b0, 1'b0);
        check_eq("ldur_ex_alu_src", 32'(exc_a.alu_src), 32'd1);
        check_eq("ldur_ex_imm", 32'(exc_a.imm), 32'd0);
        idle();
        check_eq("ldur_mem_write", 32'(memc_a.mem_write), 32'd0);
        idle();
        check_eq("ldur_wb", 32'(wbc_a), 32'b11);

        // STUR then ADDS back-to-back.
        step(1'b1, STUR, 1'b0, 1'b0);
        check_eq("stur_reg2loc", 32'(exc_a.reg2loc), 32'd0);
        step(1'b1, ADDS, 1'b0, 1'b0);
        check_eq("adds_reg2loc_flags", 32'({exc_a.reg2loc, exc_a.set_flags}), 32'b11);
        idle();
        check_eq("stur_wb_reg_write", 32'(wbc_a.reg_write), 32'd0);
        idle();
        check_eq("adds_wb_reg_write", 32'(wbc_a.reg_write), 32'd1);

        // SUBS held in EX by a two-cycle stall, then reaches MEM once.
        step(1'b1, SUBS, 1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, ADDI, 1'b1, 1'b0);
            check_eq("stall_ex_held", 32'(exc_a.set_flags), 32'd1);
            check_eq("stall_mem_bubble", 32'(memv_a), 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            idle();
            if (memv_a === 1'b1) cnt++;
        end
        check_eq("subs_mem_once", 32'(cnt), 32'd1);

        // CBZ then flush with ADDI presented: ADDI must vanish.
        step(1'b1, CBZ, 1'b0, 1'b0);
        step(1'b1, ADDI, 1'b0, 1'b1);
        check_eq("flush_ex_valid", 32'(exv_a), 32'd0);
        check_eq("flush_cbz_in_mem", 32'(memc_a.branch), 32'd1);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            idle();
            if (wbc_a.reg_write === 1'b1) cnt++;
        end
        check_eq("flush_no_reg_write", 32'(cnt), 32'd0);

        // Illegal opcode pulse, and BL illegal only when BL support is off.
        step(1'b1, BAD, 1'b0, 1'b0);
        check_eq("bad_illegal", 32'(ill_a), 32'd1);
        check_eq("bad_ex_ctrl", 32'(exc_a), 32'd0);
        idle();
        check_eq("bad_illegal_pulse", 32'(ill_a), 32'd0);
        step(1'b1, BL, 1'b0, 1'b0);
        check_eq("bl_nobl_illegal", 32'(ill_b), 32'd1);
        check_eq("bl_legal", 32'(ill_a), 32'd0);
        step(1'b1, BAD, 1'b1, 1'b1);

        // Random traffic with a mid-run asynchronous reset.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                in_valid = 1'b1; opcode = rand_op();
                rst = 1'b0;
                #1;
                model_reset();
                check_all();
                @(negedge clk); #1 check_all();
                rst = 1'b1;
            end
            step($urandom_range(0, 9) < 8, rand_op(), $urandom_range(0, 9) < 2,
                 $urandom_range(0, 9) < 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
